// File: rtl/sample_scheduler_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sample_scheduler_pkg: shared raster types and subsample decode.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sample_scheduler_pkg;

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } sched_state_e;

    // One-hot sample-rate codes (samples per pixel).
    localparam logic [3:0] c_ss_rate_1  = 4'b1000;
    localparam logic [3:0] c_ss_rate_4  = 4'b0100;
    localparam logic [3:0] c_ss_rate_16 = 4'b0010;
    localparam logic [3:0] c_ss_rate_64 = 4'b0001;

    // Right-shift applied to one pixel (1 << RADIX) to get the sample step.
    localparam logic [1:0] c_shift_1  = 2'd0;
    localparam logic [1:0] c_shift_4  = 2'd1;
    localparam logic [1:0] c_shift_16 = 2'd2;
    localparam logic [1:0] c_shift_64 = 2'd3;

    function automatic logic [1:0] step_shift(input logic [3:0] sub_sample);
        logic [1:0] shift;
        case (sub_sample)
            c_ss_rate_1:  shift = c_shift_1;
            c_ss_rate_4:  shift = c_shift_4;
            c_ss_rate_16: shift = c_shift_16;
            c_ss_rate_64: shift = c_shift_64;
            default:      shift = c_shift_1;
        endcase
        return shift;
    endfunction

endpackage : sample_scheduler_pkg
`default_nettype wire

// File: rtl/sample_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sample_scheduler_if: triangle-in / sample-out bundle for the sampler. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sample_scheduler_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);

    logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U  [COLORS];
    logic signed [SIGFIG-1:0] box_R13S    [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnH;

    logic                     halt_R13H;
    logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U  [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H,
               subSample_RnnnnU, halt_RnnnnH,
        input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H,
               subSample_RnnnnU, halt_RnnnnH,
        output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

endinterface : sample_scheduler_if
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sample_scheduler: walks a triangle's bounding box in raster order.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sample_scheduler_if.slave bus
);

    localparam logic [SIGFIG-1:0] c_step_base = SIGFIG'(1) << RADIX;

    sched_state_e             state_q,  state_d;
    logic signed [SIGFIG-1:0] tri_q     [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d     [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q   [COLORS];
    logic        [SIGFIG-1:0] color_d   [COLORS];
    logic signed [SIGFIG-1:0] box_q     [2][2];
    logic signed [SIGFIG-1:0] box_d     [2][2];
    logic signed [SIGFIG-1:0] sample_q  [2];
    logic signed [SIGFIG-1:0] sample_d  [2];
    logic        [SIGFIG-1:0] step_q,   step_d;
    logic                     valid_q,  valid_d;
    logic                     halt_q,   halt_d;

    // One extra bit of headroom so x+step near the top of range cannot wrap.
    logic signed [SIGFIG:0]   w_x_next, w_y_next;
    logic signed [SIGFIG:0]   w_ur_x,   w_ur_y;
    logic                     w_x_fits, w_y_fits;

    assign w_x_next = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    assign w_y_next = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    assign w_ur_x   = $signed({box_q[1][0][SIGFIG-1], box_q[1][0]});
    assign w_ur_y   = $signed({box_q[1][1][SIGFIG-1], box_q[1][1]});
    assign w_x_fits = (w_x_next <= w_ur_x);
    assign w_y_fits = (w_y_next <= w_ur_y);

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        step_d   = step_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        halt_d   = halt_q;

        case (state_q)
            ST_WAIT: begin
                if (bus.validTri_R13H && !bus.halt_RnnnnH) begin
                    tri_d       = bus.tri_R13S;
                    color_d     = bus.color_R13U;
                    box_d       = bus.box_R13S;
                    step_d      = c_step_base >> step_shift(bus.subSample_RnnnnU);
                    sample_d[0] = bus.box_R13S[0][0];
                    sample_d[1] = bus.box_R13S[0][1];
                    valid_d     = 1'b1;
                    halt_d      = 1'b1;
                    state_d     = ST_TEST;
                end
            end
            ST_TEST: begin
                if (!bus.halt_RnnnnH) begin
                    if (w_x_fits) begin
                        sample_d[0] = w_x_next[SIGFIG-1:0];
                    end else if (w_y_fits) begin
                        sample_d[0] = box_q[0][0];
                        sample_d[1] = w_y_next[SIGFIG-1:0];
                    end else begin
                        // Last sample has been shown for one unhalted cycle.
                        valid_d = 1'b0;
                        halt_d  = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                halt_d  = 1'b0;
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WAIT;
            tri_q    <= '{default: '0};
            color_q  <= '{default: '0};
            box_q    <= '{default: '0};
            sample_q <= '{default: '0};
            step_q   <= '0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            sample_q <= sample_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
        end
    end

    assign bus.halt_R13H      = halt_q;
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = sample_q;
    assign bus.validSamp_R14H = valid_q;

endmodule : sample_scheduler
`default_nettype wire

// File: tb/tb_sample_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sample_scheduler: randomized bench against a raster-order model.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sample_scheduler;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef struct {
        longint x;
        longint y;
    } pt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    longint exp_tri [VERTS][AXIS];
    longint exp_col [COLORS];
    pt_t    exp_q   [$];

    sample_scheduler_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

    sample_scheduler #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Pixel is 1<<RADIX; N samples per pixel means sqrt(N) samples per side.
    function automatic longint step_of(input logic [3:0] sub);
        case (sub)
            4'b1000: return (longint'(1) << RADIX) / 1;
            4'b0100: return (longint'(1) << RADIX) / 2;
            4'b0010: return (longint'(1) << RADIX) / 4;
            default: return (longint'(1) << RADIX) / 8;
        endcase
    endfunction

    task automatic build_model(input longint llx, input longint lly, input longint urx,
                               input longint ury, input longint step);
        exp_q.delete();
        for (longint y = lly; y <= ury; y += step)
            for (longint x = llx; x <= urx; x += step)
                exp_q.push_back('{x: x, y: y});
    endtask

    task automatic scramble_inputs();
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                bus.tri_R13S[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            bus.color_R13U[c] = SIGFIG'($urandom);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                bus.box_R13S[i][j] = SIGFIG'($urandom);
    endtask

    task automatic check_data(input string tag);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                check_value($sformatf("%s_tri%0d%0d", tag, v, a), bus.tri_R14S[v][a], exp_tri[v][a]);
        for (int c = 0; c < COLORS; c++)
            check_value($sformatf("%s_col%0d", tag, c), {40'd0, bus.color_R14U[c]}, exp_col[c]);
    endtask

    // halt_mode: 0 none, 1 random, 2 three-cycle stall on the second sample.
    task automatic run_tri(input longint llx, input longint lly, input longint urx,
                           input longint ury, input logic [3:0] sub, input int halt_mode,
                           input bit pulses, input int pre_halt);
        int idx;
        int held;
        int budget;
        bit halted;
        logic signed [SIGFIG-1:0] tv;
        logic        [SIGFIG-1:0] cv;

        build_model(llx, lly, urx, ury, step_of(sub));
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) begin
                tv = SIGFIG'($urandom);
                bus.tri_R13S[v][a] = tv;
                exp_tri[v][a] = tv;
            end
        for (int c = 0; c < COLORS; c++) begin
            cv = SIGFIG'($urandom);
            bus.color_R13U[c] = cv;
            exp_col[c] = longint'(cv);
        end
        bus.box_R13S[0][0]   = SIGFIG'(llx);
        bus.box_R13S[0][1]   = SIGFIG'(lly);
        bus.box_R13S[1][0]   = SIGFIG'(urx);
        bus.box_R13S[1][1]   = SIGFIG'(ury);
        bus.subSample_RnnnnU = sub;
        bus.validTri_R13H    = 1'b1;
        bus.halt_RnnnnH      = (pre_halt > 0);

        for (int i = 0; i < pre_halt; i++) begin
            @(posedge clk); #1;
            check_value("wait_halt_valid", {63'd0, bus.validSamp_R14H}, 0);
            check_value("wait_halt_busy",  {63'd0, bus.halt_R13H}, 0);
        end
        bus.halt_RnnnnH = 1'b0;
        @(posedge clk); #1;
        bus.validTri_R13H = 1'b0;
        check_data("accept");

        idx    = 0;
        held   = 0;
        budget = exp_q.size() * 4 + 16;
        while (idx < exp_q.size() && budget > 0) begin
            check_value("valid", {63'd0, bus.validSamp_R14H}, 1);
            check_value("busy",  {63'd0, bus.halt_R13H}, 1);
            check_value($sformatf("samp_x%0d", idx), bus.sample_R14S[0], exp_q[idx].x);
            check_value($sformatf("samp_y%0d", idx), bus.sample_R14S[1], exp_q[idx].y);
            case (halt_mode)
                1:       halted = ($urandom_range(3) == 0);
                2: begin
                    halted = (idx == 1 && held < 3);
                    if (halted) held++;
                end
                default: halted = 1'b0;
            endcase
            bus.halt_RnnnnH = halted;
            if (pulses) begin
                bus.validTri_R13H    = 1'($urandom_range(1));
                bus.subSample_RnnnnU = 4'b0001 << $urandom_range(3);
                scramble_inputs();
            end
            @(posedge clk); #1;
            budget--;
            if (!halted) idx++;
        end
        bus.validTri_R13H = 1'b0;
        bus.halt_RnnnnH   = 1'b0;
        if (budget == 0)
            check_value("sample_timeout", idx, exp_q.size());
        check_value("done_valid", {63'd0, bus.validSamp_R14H}, 0);
        check_value("done_busy",  {63'd0, bus.halt_R13H}, 0);
        check_data("hold");
    endtask

    task automatic reset_mid_triangle();
        scramble_inputs();
        bus.box_R13S[0][0]   = '0;
        bus.box_R13S[0][1]   = '0;
        bus.box_R13S[1][0]   = SIGFIG'(2048);
        bus.box_R13S[1][1]   = SIGFIG'(1024);
        bus.subSample_RnnnnU = 4'b1000;
        bus.validTri_R13H    = 1'b1;
        @(posedge clk); #1;
        bus.validTri_R13H = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_pre_x", bus.sample_R14S[0], 2048);
        check_value("rst_pre_v", {63'd0, bus.validSamp_R14H}, 1);
        #1 rst = 1'b0;
        #1;
        check_value("rst_async_valid", {63'd0, bus.validSamp_R14H}, 0);
        check_value("rst_async_busy",  {63'd0, bus.halt_R13H}, 0);
        check_value("rst_async_x",     bus.sample_R14S[0], 0);
        check_value("rst_async_tri",   bus.tri_R14S[0][0], 0);
        check_value("rst_async_col",   {40'd0, bus.color_R14U[0]}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_value("post_rst_valid", {63'd0, bus.validSamp_R14H}, 0);
            check_value("post_rst_busy",  {63'd0, bus.halt_R13H}, 0);
            check_value("post_rst_y",     bus.sample_R14S[1], 0);
        end
    endtask

    initial begin
        bus.validTri_R13H    = 1'b0;
        bus.halt_RnnnnH      = 1'b0;
        bus.subSample_RnnnnU = 4'b1000;
        scramble_inputs();

        repeat (3) @(posedge clk);
        #1;
        check_value("reset_valid", {63'd0, bus.validSamp_R14H}, 0);
        check_value("reset_busy",  {63'd0, bus.halt_R13H}, 0);
        check_value("reset_x",     bus.sample_R14S[0], 0);
        check_value("reset_y",     bus.sample_R14S[1], 0);
        check_value("reset_tri",   bus.tri_R14S[2][2], 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run_tri(0, 0, 2048, 1024, 4'b1000, 0, 1'b0, 0);
        run_tri(0, 0, 1024, 0,    4'b0100, 0, 1'b0, 0);
        run_tri(0, 0, 2048, 1024, 4'b1000, 2, 1'b0, 0);
        run_tri(0, 0, 2048, 1024, 4'b1000, 0, 1'b1, 0);
        run_tri(512, 512, 512, 512, 4'b0001, 0, 1'b0, 0);
        run_tri(0, 0, 1500, 0,    4'b1000, 0, 1'b0, 0);
        run_tri(8387607, -300, 8388607, 8388607 - 8388000, 4'b1000, 0, 1'b0, 2);
        run_tri(-2000, -1000, -1000, -700, 4'b0010, 1, 1'b1, 1);

        reset_mid_triangle();
        run_tri(100, 200, 900, 600, 4'b0100, 0, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            longint llx, lly;
            llx = longint'($urandom_range(8000)) - 4000;
            lly = longint'($urandom_range(8000)) - 4000;
            run_tri(llx, lly, llx + longint'($urandom_range(1500)),
                    lly + longint'($urandom_range(1500)),
                    4'b0001 << $urandom_range(3), 1, 1'b1, int'($urandom_range(2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sample_scheduler
`default_nettype wire
